// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the fetch PC, the F/D pipeline register and
// the bring-up event counters. Redirects from execute take priority over
// load-use stalls; a redirect loads a NOP bubble into F/D.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h01000000,
  parameter logic [31:0] NOP_INST = 32'h00000013
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  output logic [31:0] f_pc,
  output logic [31:0] d_pc,
  output logic [31:0] d_inst,
  output logic        d_valid,
  output logic [31:0] fetch_count,
  output logic [31:0] flush_count
);

  logic [31:0] f_pc_q, f_pc_d;
  logic [31:0] d_pc_q, d_pc_d;
  logic [31:0] d_inst_q, d_inst_d;
  logic        d_valid_q, d_valid_d;
  logic [31:0] fetch_count_q, fetch_count_d;
  logic [31:0] flush_count_q, flush_count_d;

  // Next-state selection: redirect > stall > sequential fetch.
  always_comb begin
    f_pc_d        = f_pc_q;
    d_pc_d        = d_pc_q;
    d_inst_d      = d_inst_q;
    d_valid_d     = d_valid_q;
    fetch_count_d = fetch_count_q;
    flush_count_d = flush_count_q;
    if (redirect) begin
      // Word-align the target; the word fetched this cycle is wrong-path.
      f_pc_d        = {redirect_pc[31:2], 2'b00};
      d_pc_d        = f_pc_q;
      d_inst_d      = NOP_INST;
      d_valid_d     = 1'b0;
      flush_count_d = flush_count_q + 32'd1;
    end else if (!stall) begin
      f_pc_d        = f_pc_q + 32'd4;
      d_pc_d        = f_pc_q;
      d_inst_d      = imem_data;
      d_valid_d     = 1'b1;
      fetch_count_d = fetch_count_q + 32'd1;
    end
  end

  // State registers with synchronous reset overriding every other input.
  always_ff @(posedge clock) begin
    if (reset) begin
      f_pc_q        <= RESET_PC;
      d_pc_q        <= RESET_PC;
      d_inst_q      <= NOP_INST;
      d_valid_q     <= 1'b0;
      fetch_count_q <= 32'd0;
      flush_count_q <= 32'd0;
    end else begin
      f_pc_q        <= f_pc_d;
      d_pc_q        <= d_pc_d;
      d_inst_q      <= d_inst_d;
      d_valid_q     <= d_valid_d;
      fetch_count_q <= fetch_count_d;
      flush_count_q <= flush_count_d;
    end
  end

  // Instruction memory is addressed straight from state, never from inputs.
  assign imem_addr   = f_pc_q;
  assign f_pc        = f_pc_q;
  assign d_pc        = d_pc_q;
  assign d_inst      = d_inst_q;
  assign d_valid     = d_valid_q;
  assign fetch_count = fetch_count_q;
  assign flush_count = flush_count_q;

endmodule
